// File: rtl/fft_slot_scheduler.sv
// Ping-pong slot scheduler for the FFT load/compute/readout ports.
// Per-port grant FSMs with watchdogs, frame counter and sticky error.
module fft_slot_scheduler #(
  parameter int TIMEOUT = 1023,
  parameter int CNTW    = 10,
  parameter int FRAMEW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic              cmp_req,
  input  logic              out_req,
  input  logic              ld_done,
  input  logic              cmp_done,
  input  logic              out_done,
  input  logic              err_clr,
  output logic              ld_gnt,
  output logic              cmp_gnt,
  output logic              out_gnt,
  output logic              ld_slot,
  output logic              cmp_slot,
  output logic              out_slot,
  output logic [3:0]        slot_state,
  output logic [FRAMEW-1:0] frames_done,
  output logic              err
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} st_t;

  localparam logic [CNTW-1:0] WD_LAST = CNTW'(TIMEOUT - 1);

  st_t               r_st [3];
  st_t               w_st_nxt [3];
  logic [2:0]        r_ptr;
  logic [2:0]        w_ptr_nxt;
  logic [CNTW-1:0]   r_wd [3];
  logic [CNTW-1:0]   w_wd_nxt [3];
  logic [1:0]        r_slot [2];
  logic [1:0]        w_slot_nxt [2];
  logic [FRAMEW-1:0] r_frames;
  logic [FRAMEW-1:0] w_frames_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_run;
  logic [2:0]        w_req;
  logic [2:0]        w_done;
  logic [2:0]        w_acc;
  logic [2:0]        w_to;
  logic [2:0]        w_stray;
  logic [2:0]        w_start;
  logic [2:0]        w_adv;
  logic [1:0]        w_hits [2];
  logic              w_set;

  assign w_req  = {out_req, cmp_req, ld_req};
  assign w_done = {out_done, cmp_done, ld_done};

  // Port p accepts slot state p and advances it to (p+1) mod 3.
  always_comb begin
    w_slot_nxt = r_slot;
    w_hits[0]  = 2'd0;
    w_hits[1]  = 2'd0;
    w_acc      = '0;
    w_to       = '0;
    w_stray    = '0;
    w_start    = '0;
    w_adv      = '0;
    w_ptr_nxt  = r_ptr;
    for (int p = 0; p < 3; p++) begin
      w_acc[p]   = (r_st[p] == GRANT) && w_done[p];
      w_to[p]    = (r_st[p] == GRANT) && !w_done[p] &&
                   (r_wd[p] == WD_LAST);
      w_stray[p] = (r_st[p] == IDLE) && w_done[p];
      w_start[p] = r_run && (r_st[p] == IDLE) && w_req[p] &&
                   (r_slot[r_ptr[p]] == 2'(p));
      if (w_acc[p])
        w_hits[r_ptr[p]] = w_hits[r_ptr[p]] + 2'd1;
    end
    for (int p = 0; p < 3; p++) begin
      w_adv[p]    = w_acc[p] && (w_hits[r_ptr[p]] == 2'd1);
      w_st_nxt[p] = r_st[p];
      w_wd_nxt[p] = '0;
      unique case (r_st[p])
        IDLE: begin
          if (w_start[p])
            w_st_nxt[p] = GRANT;
        end
        GRANT: begin
          if (w_acc[p] || w_to[p] || !w_req[p])
            w_st_nxt[p] = IDLE;
          else
            w_wd_nxt[p] = r_wd[p] + CNTW'(1);
        end
      endcase
      if (w_adv[p]) begin
        w_ptr_nxt[p]           = ~r_ptr[p];
        w_slot_nxt[r_ptr[p]]   = 2'((p + 1) % 3);
      end
    end
    w_set        = (|w_to) || (|w_stray) || (|(w_acc & ~w_adv));
    w_err_nxt    = w_set || (r_err && !err_clr);
    w_frames_nxt = r_frames + FRAMEW'(w_adv[2]);
  end

  // r_run holds off grants for the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        r_st[p] <= IDLE;
        r_wd[p] <= '0;
      end
      r_slot[0] <= 2'b00;
      r_slot[1] <= 2'b00;
      r_ptr     <= '0;
      r_frames  <= '0;
      r_err     <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        r_st[p] <= w_st_nxt[p];
        r_wd[p] <= w_wd_nxt[p];
      end
      r_slot[0] <= w_slot_nxt[0];
      r_slot[1] <= w_slot_nxt[1];
      r_ptr     <= w_ptr_nxt;
      r_frames  <= w_frames_nxt;
      r_err     <= w_err_nxt;
      r_run     <= 1'b1;
    end
  end

  assign ld_gnt      = (r_st[0] == GRANT);
  assign cmp_gnt     = (r_st[1] == GRANT);
  assign out_gnt     = (r_st[2] == GRANT);
  assign ld_slot     = r_ptr[0];
  assign cmp_slot    = r_ptr[1];
  assign out_slot    = r_ptr[2];
  assign slot_state  = {r_slot[1], r_slot[0]};
  assign frames_done = r_frames;
  assign err         = r_err;

endmodule

// File: tb/tb_fft_slot_scheduler.sv
// Scoreboard bench for fft_slot_scheduler: a frame-level reference model
// queues expected outputs per cycle, a monitor pops and compares them.
module tb_fft_slot_scheduler;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req_v = '0;
  logic [2:0]    done_v = '0;
  logic          err_clr = 1'b0;
  logic          ld_gnt, cmp_gnt, out_gnt;
  logic          ld_slot, cmp_slot, out_slot;
  logic [3:0]    slot_state;
  logic [FW-1:0] frames_done;
  logic          err;

  always #5 clk = ~clk;

  fft_slot_scheduler #(.TIMEOUT(TO), .CNTW(CW), .FRAMEW(FW)) dut (
    .clk(clk), .rst(rst),
    .ld_req(req_v[0]), .cmp_req(req_v[1]), .out_req(req_v[2]),
    .ld_done(done_v[0]), .cmp_done(done_v[1]), .out_done(done_v[2]),
    .err_clr(err_clr),
    .ld_gnt(ld_gnt), .cmp_gnt(cmp_gnt), .out_gnt(out_gnt),
    .ld_slot(ld_slot), .cmp_slot(cmp_slot), .out_slot(out_slot),
    .slot_state(slot_state), .frames_done(frames_done), .err(err)
  );

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] slot;
    logic [3:0] ss;
    logic [7:0] fr;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: slot contents 0=empty 1=loaded 2=computed,
  // each port holds a pointer, a granted flag and its grant age.
  int m_slot [2];
  int m_ptr  [3];
  bit m_gr   [3];
  int m_age  [3];
  int m_fr;
  bit m_err;
  bit m_rdy;
  int m_outs = 0;

  function automatic void chk(string nm, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) m_slot[i] = 0;
    for (int p = 0; p < 3; p++) begin
      m_ptr[p] = 0; m_gr[p] = 0; m_age[p] = 0;
    end
    m_fr = 0; m_err = 0; m_rdy = 0;
  endfunction

  function automatic void model_step();
    int  n_slot [2];
    int  n_ptr  [3];
    bit  n_gr   [3];
    int  n_age  [3];
    int  hits   [2];
    int  n_fr;
    bit  e;
    exp_t x;
    n_slot = m_slot; n_ptr = m_ptr; n_gr = m_gr; n_age = m_age;
    n_fr = m_fr; e = 0; hits[0] = 0; hits[1] = 0;
    for (int p = 0; p < 3; p++)
      if (m_gr[p] && done_v[p]) hits[m_ptr[p]]++;
    for (int p = 0; p < 3; p++) begin
      if (m_gr[p]) begin
        if (done_v[p]) begin
          n_gr[p] = 0;
          if (hits[m_ptr[p]] > 1) e = 1;
          else begin
            n_slot[m_ptr[p]] = (p + 1) % 3;
            n_ptr[p] = 1 - m_ptr[p];
            if (p == 2) begin
              n_fr = (m_fr + 1) % 256;
              m_outs++;
            end
          end
        end else if (m_age[p] == TO) begin
          n_gr[p] = 0; e = 1;
        end else if (!req_v[p]) n_gr[p] = 0;
        else n_age[p] = m_age[p] + 1;
      end else begin
        if (done_v[p]) e = 1;
        if (m_rdy && req_v[p] && m_slot[m_ptr[p]] == p) begin
          n_gr[p] = 1; n_age[p] = 1;
        end
      end
    end
    if (e) m_err = 1;
    else if (err_clr) m_err = 0;
    m_slot = n_slot; m_ptr = n_ptr; m_gr = n_gr; m_age = n_age;
    m_fr = n_fr; m_rdy = 1;
    for (int p = 0; p < 3; p++) begin
      x.gnt[p]  = m_gr[p];
      x.slot[p] = m_ptr[p][0];
    end
    x.ss  = {2'(m_slot[1]), 2'(m_slot[0])};
    x.fr  = 8'(m_fr);
    x.err = m_err;
    q.push_back(x);
  endfunction

  // Monitor: compares one queued expectation per clock, 2 units after the edge.
  exp_t mx;
  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      mx = q.pop_front();
      chk("gnt", int'({out_gnt, cmp_gnt, ld_gnt}), int'(mx.gnt));
      if (mx.gnt[0]) chk("ld_slot", int'(ld_slot), int'(mx.slot[0]));
      if (mx.gnt[1]) chk("cmp_slot", int'(cmp_slot), int'(mx.slot[1]));
      if (mx.gnt[2]) chk("out_slot", int'(out_slot), int'(mx.slot[2]));
      chk("slot_state", int'(slot_state), int'(mx.ss));
      chk("frames_done", int'(frames_done), int'(mx.fr));
      chk("err", int'(err), int'(mx.err));
    end
  end

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_rst_vals();
    chk("rst_gnt", int'({out_gnt, cmp_gnt, ld_gnt}), 0);
    chk("rst_slot", int'({out_slot, cmp_slot, ld_slot}), 0);
    chk("rst_state", int'(slot_state), 0);
    chk("rst_frames", int'(frames_done), 0);
    chk("rst_err", int'(err), 0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1 chk_rst_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic xfer(int p, int slack);
    req_v[p] = 1'b1;
    step();
    repeat (slack) step();
    done_v[p] = 1'b1;
    req_v[p]  = 1'b0;
    step();
    done_v[p] = 1'b0;
  endtask

  initial begin
    int n;
    int start;
    repeat (2) @(negedge clk);
    chk_rst_vals();
    req_v[0] = 1'b1;
    rst = 1'b0;
    model_reset();
    // First edge after release may not grant, second may.
    step();
    chk("rel_gnt_edge1", int'(ld_gnt), 0);
    step();
    chk("rel_gnt_edge2", int'(ld_gnt), 1);
    req_v[0] = 1'b0;
    step();
    chk("abort_gnt", int'(ld_gnt), 0);
    chk("abort_state", int'(slot_state), 0);
    step();

    // Nominal frame
    req_v[0] = 1'b1;
    step();
    chk("nom_ld_gnt", int'(ld_gnt), 1);
    chk("nom_ld_slot", int'(ld_slot), 0);
    repeat (4) step();
    done_v[0] = 1'b1;
    req_v[0]  = 1'b0;
    step();
    done_v[0] = 1'b0;
    chk("nom_loaded", int'(slot_state), 4'b0001);
    chk("nom_ld_drop", int'(ld_gnt), 0);
    xfer(1, 2);
    xfer(2, 2);
    chk("nom_empty", int'(slot_state), 0);
    chk("nom_frames", int'(frames_done), 1);

    // Reset in the middle of a load grant
    req_v[0] = 1'b1;
    step();
    chk("mid_ld_gnt", int'(ld_gnt), 1);
    do_reset();
    req_v[0] = 1'b0;
    step();

    // Pipelining: compute slot 0 while loading slot 1
    xfer(0, 1);
    req_v[1:0] = 2'b11;
    step();
    chk("pipe_gnts", int'({cmp_gnt, ld_gnt}), 3);
    chk("pipe_ld_slot", int'(ld_slot), 1);
    chk("pipe_cmp_slot", int'(cmp_slot), 0);
    done_v[1:0] = 2'b11;
    req_v[1:0]  = 2'b00;
    step();
    done_v = '0;
    chk("pipe_state", int'(slot_state), 4'b0110);
    xfer(2, 0);
    xfer(1, 0);
    xfer(2, 0);

    // Backpressure with both slots loaded
    xfer(0, 0);
    xfer(0, 0);
    req_v[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("bp_ld_gnt", int'(ld_gnt), 0);
    end
    chk("bp_err", int'(err), 0);
    xfer(1, 0);
    xfer(2, 0);
    step();
    chk("bp_release_gnt", int'(ld_gnt), 1);
    chk("bp_release_slot", int'(ld_slot), 0);
    done_v[0] = 1'b1;
    req_v[0]  = 1'b0;
    step();
    done_v[0] = 1'b0;

    // Watchdog timeout on compute (slot 1)
    req_v[1] = 1'b1;
    step();
    repeat (7) step();
    chk("to_gnt_held", int'(cmp_gnt), 1);
    step();
    chk("to_gnt_drop", int'(cmp_gnt), 0);
    chk("to_err", int'(err), 1);
    chk("to_state", int'(slot_state), 4'b0101);
    req_v[1] = 1'b0;
    err_clr  = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", int'(err), 0);

    // Stray done, then done on the timeout cycle
    done_v[2] = 1'b1;
    step();
    done_v[2] = 1'b0;
    chk("stray_err", int'(err), 1);
    chk("stray_state", int'(slot_state), 4'b0101);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    req_v[1] = 1'b1;
    step();
    repeat (7) step();
    done_v[1] = 1'b1;
    req_v[1]  = 1'b0;
    step();
    done_v[1] = 1'b0;
    chk("to_done_err", int'(err), 0);
    chk("to_done_state", int'(slot_state), 4'b1001);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(7) == 0) req_v[p] = ~req_v[p];
        if (m_gr[p]) done_v[p] = ($urandom_range(3) == 0);
        else done_v[p] = ($urandom_range(99) == 0);
      end
      err_clr = ($urandom_range(15) == 0);
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end

    // Frame counter wrap after 256 readouts
    req_v = '0; done_v = '0; err_clr = 1'b0;
    do_reset();
    step();
    start = m_outs;
    n = 0;
    req_v = 3'b111;
    while (m_outs - start < 256 && n < 6000) begin
      for (int p = 0; p < 3; p++) done_v[p] = m_gr[p];
      step();
      n++;
    end
    done_v = '0;
    req_v  = '0;
    chk("wrap_count", m_outs - start, 256);
    chk("wrap_frames", int'(frames_done), 0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fft_slot_scheduler.md
FFT_SLOT_SCHEDULER -- requirements
Module: fft_slot_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum grant-held cycles without a done pulse.
REQ-002 Parameter CNTW, default 10: width of each per-port watchdog counter; SHALL satisfy 2^CNTW > TIMEOUT.
REQ-003 Parameter FRAMEW, default 8: width of the completed-frame counter.
REQ-004 Port list SHALL be exactly:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- ld_req, cmp_req, out_req  in  1 each  load / compute / readout requests; level-held.
- ld_done, cmp_done, out_done  in  1 each  single-cycle completion pulses from each requester.
- err_clr  in  1  synchronous clear of err.
- ld_gnt, cmp_gnt, out_gnt  out  1 each  registered grants.
- ld_slot, cmp_slot, out_slot  out  1 each  slot index for the granted port; valid only while the matching grant is high.
- slot_state  out  4  bits [1:0] = slot 0 state, bits [3:2] = slot 1 state.
- frames_done  out  FRAMEW  count of completed readouts.
- err  out  1  sticky protocol/timeout error.

Function
REQ-005 Two frame slots (ping-pong bank sets); each slot state SHALL be one of EMPTY=00, LOADED=01, COMPUTED=10; 11 SHALL never occur.
REQ-006 Each port SHALL keep a 1-bit pointer (ld_ptr, cmp_ptr, out_ptr), so frames move load -> compute -> readout in strict order.
REQ-007 Port state machine, per port: IDLE -> GRANT -> IDLE.
REQ-008 IDLE -> GRANT SHALL occur when req is high and slot[ptr] holds the eligible state: EMPTY for ld, LOADED for cmp, COMPUTED for out.
REQ-009 The grant SHALL go high on the clock edge after the cycle in which REQ-008 is met, giving 1-cycle request-to-grant latency; *_slot SHALL equal ptr.
REQ-010 In GRANT, a done pulse SHALL advance slot[ptr] on the next edge (EMPTY->LOADED, LOADED->COMPUTED, COMPUTED->EMPTY), toggle ptr, drop gnt, and return to IDLE.
REQ-011 In GRANT, req low without done (abort) SHALL drop gnt on the next edge and return to IDLE; slot state and ptr stay unchanged.
REQ-012 Watchdog: while in GRANT, the counter SHALL increment each cycle. It SHALL clear on entering GRANT.
REQ-013 Watchdog timeout: when the count reaches TIMEOUT without done, the port SHALL drop gnt, set err, and return to IDLE; slot and ptr stay unchanged.
REQ-014 Done and timeout in the same cycle: done SHALL win; no err is set.
REQ-015 Done and req-low in the same cycle: SHALL be treated as done.
REQ-016 A done pulse while that port's gnt is low SHALL be ignored for slot state and SHALL set err.
REQ-017 All three ports SHALL evaluate independently in the same cycle. The state rules make concurrent grants always target distinct slots; any attempt by two ports to update the same slot in one cycle SHALL set err and leave that slot unchanged.
REQ-018 A port SHALL NOT re-grant in the same cycle its gnt drops; minimum one IDLE cycle.
REQ-019 frames_done SHALL increment by 1 on each accepted out_done and wrap 2^FRAMEW-1 -> 0.
REQ-020 err SHALL clear on err_clr. If err_clr coincides with a new error event, set SHALL win.
REQ-021 Both slots LOADED: a ld_req SHALL wait in IDLE with gnt low indefinitely; no error.

Reset
REQ-022 While rst is high, outputs SHALL be immediately and asynchronously: all gnt=0, *_slot=0, slot_state=0000, frames_done=0, err=0. Internally, pointers=0, watchdogs=0, all ports IDLE.
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously and discard the partial transfer; slot returns to EMPTY.
REQ-024 After rst falls, the first grant SHALL be possible on the second rising edge.

Verification
REQ-025 Nominal frame: ld_req high at cycle 0 -> ld_gnt=1, ld_slot=0 at cycle 1. ld_done at cycle 5 -> slot_state=0001 and ld_gnt=0 at cycle 6. Complete cmp then out in order -> slot_state=0000, frames_done=1.
REQ-026 Pipelining: load slot 0, then hold cmp_req and ld_req together -> cmp_gnt with cmp_slot=0 and ld_gnt with ld_slot=1 both high in the same cycle.
REQ-027 Backpressure: two loads done, no compute, ld_req held high -> ld_gnt stays 0 for 100 cycles, err=0. Then one full cmp+out on slot 0 -> ld_gnt rises with ld_slot=0.
REQ-028 Timeout: TIMEOUT=8, cmp granted, no cmp_done -> cmp_gnt falls after 8 grant cycles, err=1, slot_state unchanged. err_clr -> err=0 next cycle.
REQ-029 Protocol errors: out_done pulsed with out_gnt=0 -> err=1, slot_state unchanged. Done coincident with the timeout cycle -> slot advances, err=0.
REQ-030 Reset mid-grant: assert rst during ld_gnt=1 -> ld_gnt=0 in the same cycle, all outputs at reset values. 256 completed frames with FRAMEW=8 -> frames_done wraps to 0.
